pkt_dmem_bridge: RTL and testbench
==================================

// Module: pkt_dmem_bridge
// PURPOSE
//  Packet buffer between the NetFPGA packet stream and the pipeline_datapath data-memory port.
//  It captures one packet into an internal 72-bit-wide buffer and hands it to the core for processing.
//  Once the core signals done, it drains the (possibly modified) packet downstream in order.
//  There is one packet in flight. The core sees the buffer as 32-bit words.
// PARAMETERS
//  DATA_WIDTH  64  packet data width
//  CTRL_WIDTH  8   packet ctrl width
//  ADDR_WIDTH  8   log2 buffer depth in 72-bit words (depth 256)
// PORTS
//  clk        in   1             clock, all logic on posedge
//  reset      in   1             asynchronous, active-high
//  in_data    in   DATA_WIDTH    upstream packet word
//  in_ctrl    in   CTRL_WIDTH    upstream ctrl; nonzero = header/EOP word
//  in_wr      in   1             upstream word valid
//  in_rdy     out  1             bridge accepts in_wr this cycle
//  out_data   out  DATA_WIDTH    downstream packet word
//  out_ctrl   out  CTRL_WIDTH    downstream ctrl
//  out_wr     out  1             downstream word valid
//  out_rdy    in   1             downstream can accept
//  cpu_addr   in   ADDR_WIDTH+1  32-bit word address; bit0=1 selects data[63:32], bit0=0 selects [31:0]
//  cpu_wdata  in   32            core write data
//  cpu_we     in   1             core write strobe
//  cpu_rdata  out  32            core read data, 1-cycle latency
//  pkt_ready  out  1             packet resident, core owns buffer
//  pkt_len    out  ADDR_WIDTH+1  words in resident packet
//  cpu_done   in   1             core finished, start drain
//  drop_cnt   out  32            oversize packets dropped (wraps at 2^32)
// BEHAVIOUR
//  Reset state:
//   - state=IDLE; wr_ptr=rd_ptr=0.
//   - Outputs: in_rdy=0, out_wr=0, out_data=0, out_ctrl=0, cpu_rdata=0, pkt_ready=0, pkt_len=0, drop_cnt=0.
//   - Buffer contents are undefined after reset.
//  States: IDLE, HDR, PAY, PROC, DRAIN, DROP.
//  Capture (IDLE, HDR, PAY): in_rdy=1; each in_wr stores {ctrl,data} at wr_ptr, then wr_ptr++.
//  Transitions:
//   - IDLE -> HDR on first in_wr with ctrl!=0; IDLE -> PAY on first in_wr with ctrl==0.
//   - HDR -> PAY on in_wr with ctrl==0.
//   - PAY -> PROC on in_wr with ctrl!=0 (EOP word, stored). Next cycle: pkt_ready=1, pkt_len=wr_ptr, in_rdy=0.
//   - Full: a word arriving with wr_ptr==2^ADDR_WIDTH and no EOP yet -> DROP.
//   - DROP: in_rdy=1; words are discarded until the EOP word (ctrl!=0 after payload). Then drop_cnt++, wr_ptr=0, -> IDLE. No pkt_ready.
//  PROC:
//   - cpu_we writes cpu_wdata into the addressed half-word of word cpu_addr[ADDR_WIDTH:1]; ctrl is unchanged.
//   - cpu_done -> DRAIN next cycle; pkt_ready deasserts the same cycle.
//  cpu_rdata:
//   - Registered read of cpu_addr in every state.
//   - A read and a write to the same address in the same cycle return the old data.
//  cpu_we and cpu_done outside PROC are ignored.
//  DRAIN:
//   - A cycle with out_rdy=1 and rd_ptr<pkt_len issues a buffer read; rd_ptr++.
//   - Next cycle: out_wr=1 with that word. This 1-cycle latency is absorbed by downstream FIFO slack.
//   - After the last word is presented: wr_ptr=rd_ptr=0, pkt_len=0, -> IDLE.
//   - Word order and ctrl are preserved exactly.
//  Reset mid-operation (any state): all outputs go to reset values immediately. The packet in flight is lost and not counted.
// TESTING
//  T1 capture: 1 hdr (ctrl=FF), 6 payload, EOP (ctrl=01) -> pkt_ready=1 one cycle after EOP, pkt_len=8, in_rdy=0.
//  T2 core access: in PROC write cpu_addr=11 data CAFEF00D, read 11 -> cpu_rdata=CAFEF00D next cycle; drained word 5 data[63:32]=CAFEF00D, [31:0] unchanged.
//  T3 drain: cpu_done, out_rdy toggles 1010... -> exactly 8 out_wr pulses, order/ctrl match input, then IDLE, in_rdy=1.
//  T4 overflow (ADDR_WIDTH=3): 12-word packet -> no pkt_ready, drop_cnt=1; a following 4-word packet is captured normally, pkt_len=4.
//  T5 reset in PROC / mid-DRAIN -> pkt_ready=0, out_wr=0 same cycle; new packet captured from wr_ptr=0.
//  T6 cpu_we=1 and cpu_done=1 during PAY/IDLE -> buffer unchanged, no state change.

Source files
------------

// File: rtl/pkt_dmem_bridge.sv
// Single-packet buffer between the packet stream and the core data-memory port.
// Captures one packet, lets the core edit it as 32-bit words, then drains it in order.
module pkt_dmem_bridge #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [ADDR_WIDTH:0]   cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  cpu_we,
    output logic [31:0]           cpu_rdata,
    output logic                  pkt_ready,
    output logic [ADDR_WIDTH:0]   pkt_len,
    input  logic                  cpu_done,
    output logic [31:0]           drop_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int W     = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PAY, S_PROC, S_DRAIN, S_DROP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_pkt_len;
    logic                  r_in_rdy;
    logic                  r_out_wr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic [31:0]           r_cpu_rdata;
    logic                  r_pkt_ready;
    logic [31:0]           r_drop_cnt;
    logic                  r_drop_pay;
    logic [W-1:0]          r_mem [DEPTH];

    logic                  w_acc;
    logic                  w_capture;
    logic                  w_full;
    logic                  w_eop;
    logic                  w_cap_we;
    logic                  w_cpu_we;
    logic                  w_rd_ok;
    logic [W-1:0]          w_cpu_word;
    logic [W-1:0]          w_drain_word;

    assign w_acc        = r_in_rdy & in_wr;
    assign w_capture    = (r_state == S_IDLE) || (r_state == S_HDR) || (r_state == S_PAY);
    assign w_full       = (r_wr_ptr == PTR_FULL);
    assign w_eop        = (in_ctrl != '0);
    assign w_cap_we     = w_acc & w_capture & ~w_full;
    assign w_cpu_we     = (r_state == S_PROC) & cpu_we;
    assign w_rd_ok      = (r_state == S_DRAIN) & out_rdy & (r_rd_ptr < r_pkt_len);
    assign w_cpu_word   = r_mem[cpu_addr[ADDR_WIDTH:1]];
    assign w_drain_word = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (w_cap_we)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {in_ctrl, in_data};
        if (w_cpu_we) begin
            if (cpu_addr[0])
                r_mem[cpu_addr[ADDR_WIDTH:1]][63:32] <= cpu_wdata;
            else
                r_mem[cpu_addr[ADDR_WIDTH:1]][31:0] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_len   <= '0;
            r_in_rdy    <= 1'b0;
            r_out_wr    <= 1'b0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
            r_cpu_rdata <= '0;
            r_pkt_ready <= 1'b0;
            r_drop_cnt  <= '0;
            r_drop_pay  <= 1'b0;
        end else begin
            r_cpu_rdata <= cpu_addr[0] ? w_cpu_word[63:32] : w_cpu_word[31:0];
            r_out_wr    <= 1'b0;
            if (w_rd_ok) begin
                r_out_data <= w_drain_word[DATA_WIDTH-1:0];
                r_out_ctrl <= w_drain_word[W-1:DATA_WIDTH];
                r_out_wr   <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            case (r_state)
                S_IDLE, S_HDR, S_PAY: begin
                    r_in_rdy <= (r_state == S_IDLE) ? 1'b1 : r_in_rdy;
                    if (w_acc) begin
                        // A word arriving with the buffer full aborts the packet; an EOP
                        // arriving at that point completes the drop immediately.
                        if (w_full) begin
                            if ((r_state == S_PAY) && w_eop) begin
                                r_drop_cnt <= r_drop_cnt + 32'd1;
                                r_wr_ptr   <= '0;
                                r_state    <= S_IDLE;
                            end else begin
                                r_drop_pay <= (r_state == S_PAY) || !w_eop;
                                r_state    <= S_DROP;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_state == S_IDLE)
                                r_state <= w_eop ? S_HDR : S_PAY;
                            else if ((r_state == S_HDR) && !w_eop)
                                r_state <= S_PAY;
                            else if ((r_state == S_PAY) && w_eop) begin
                                r_state     <= S_PROC;
                                r_pkt_ready <= 1'b1;
                                r_pkt_len   <= r_wr_ptr + 1'b1;
                                r_in_rdy    <= 1'b0;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (w_acc) begin
                        if (!w_eop)
                            r_drop_pay <= 1'b1;
                        else if (r_drop_pay) begin
                            r_drop_cnt <= r_drop_cnt + 32'd1;
                            r_wr_ptr   <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_PROC: begin
                    if (cpu_done) begin
                        r_state     <= S_DRAIN;
                        r_pkt_ready <= 1'b0;
                        r_rd_ptr    <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_out_wr && (r_rd_ptr == r_pkt_len)) begin
                        r_state   <= S_IDLE;
                        r_wr_ptr  <= '0;
                        r_rd_ptr  <= '0;
                        r_pkt_len <= '0;
                        r_in_rdy  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_rdy    = r_in_rdy;
    assign out_wr    = r_out_wr;
    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;
    assign cpu_rdata = r_cpu_rdata;
    assign pkt_ready = r_pkt_ready;
    assign pkt_len   = r_pkt_len;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pkt_dmem_bridge.sv
// Scoreboard bench for pkt_dmem_bridge, built with an 8-word buffer so overflow is reachable.
module tb_pkt_dmem_bridge;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   in_data = '0;
    logic [7:0]    in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [63:0]   out_data;
    logic [7:0]    out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b0;
    logic [AW:0]   cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic [31:0]   cpu_rdata;
    logic          pkt_ready;
    logic [AW:0]   pkt_len;
    logic          cpu_done = 1'b0;
    logic [31:0]   drop_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_out = 0;
    logic [71:0]   exp_q[$];
    logic [71:0]   mon_exp;

    pkt_dmem_bridge #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .pkt_ready(pkt_ready), .pkt_len(pkt_len), .cpu_done(cpu_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented downstream word is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_wr === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("out_unexpected", {out_ctrl, out_data}, 72'h0);
                if ({out_ctrl, out_data} === 72'h0) begin
                    n_errors++;
                    $display("FAIL out_unexpected: got word with empty scoreboard expected none");
                end
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_word", {out_ctrl, out_data}, mon_exp);
            end
        end
    end

    function automatic logic [7:0] ctrl_of(input int i, input int n);
        if (i == 0) return 8'hFF;
        if (i == n - 1) return 8'h01;
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_rdy();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_in_rdy", {71'h0, ok}, 72'h1);
    endtask

    task automatic send_pkt(input int n, input logic [63:0] base, input bit poke);
        wait_rdy();
        tick();
        for (int i = 0; i < n; i++) begin
            in_wr   = 1'b1;
            in_data = base + 64'(i);
            in_ctrl = ctrl_of(i, n);
            if (poke && i == 3) begin
                cpu_we    = 1'b1;
                cpu_addr  = 4'd2;
                cpu_wdata = 32'hDEADBEEF;
                cpu_done  = 1'b1;
            end else begin
                cpu_we   = 1'b0;
                cpu_done = 1'b0;
            end
            tick();
        end
        in_wr    = 1'b0;
        in_ctrl  = '0;
        cpu_we   = 1'b0;
        cpu_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_pkt(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++)
            exp_q.push_back({ctrl_of(i, n), base + 64'(i)});
    endtask

    task automatic drain(input int n, input bit toggle);
        int  start = n_out;
        bit  done = 1'b0;
        tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        out_rdy  = 1'b1;
        @(negedge clk);
        chk("pkt_ready_drop_on_done", {71'h0, pkt_ready}, 72'h0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (toggle) out_rdy = ~out_rdy;
            @(negedge clk);
            if (in_rdy === 1'b1 && pkt_len === '0) begin
                done = 1'b1;
                break;
            end
        end
        out_rdy = 1'b0;
        chk("drain_done", {71'h0, done}, 72'h1);
        chk("drain_count", 72'(n_out - start), 72'(n));
        chk("scoreboard_empty", 72'(exp_q.size()), 72'h0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_pkt_ready", {71'h0, pkt_ready}, 72'h0);
        chk("rst_out_wr", {71'h0, out_wr}, 72'h0);
        chk("rst_pkt_len", 72'(pkt_len), 72'h0);
        chk("rst_in_rdy", {71'h0, in_rdy}, 72'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_rdy", {71'h0, in_rdy}, 72'h0);
        chk("reset_out_wr", {71'h0, out_wr}, 72'h0);
        chk("reset_out_word", {out_ctrl, out_data}, 72'h0);
        chk("reset_cpu_rdata", 72'(cpu_rdata), 72'h0);
        chk("reset_pkt_ready", {71'h0, pkt_ready}, 72'h0);
        chk("reset_pkt_len", 72'(pkt_len), 72'h0);
        chk("reset_drop_cnt", 72'(drop_cnt), 72'h0);
        #1 reset = 1'b0;

        // Core strobes while idle must be ignored.
        wait_rdy();
        tick();
        cpu_we = 1'b1; cpu_addr = 4'd0; cpu_wdata = 32'h12345678; cpu_done = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_done = 1'b0;
        @(negedge clk);
        chk("idle_poke_pkt_ready", {71'h0, pkt_ready}, 72'h0);
        chk("idle_poke_in_rdy", {71'h0, in_rdy}, 72'h1);

        // Capture an 8-word packet with ignored core strobes mid-payload.
        send_pkt(8, 64'h1111_2222_3333_0000, 1'b1);
        chk("cap_pkt_ready", {71'h0, pkt_ready}, 72'h1);
        chk("cap_pkt_len", 72'(pkt_len), 72'd8);
        chk("cap_in_rdy", {71'h0, in_rdy}, 72'h0);

        // Core access in PROC.
        tick();
        cpu_addr = 4'd2;
        tick();
        @(negedge clk);
        chk("rd_word1_lo", 72'(cpu_rdata), 72'h33330001);
        cpu_addr = 4'd11; cpu_we = 1'b1; cpu_wdata = 32'hCAFEF00D;
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_during_wr_old", 72'(cpu_rdata), 72'h11112222);
        tick();
        @(negedge clk);
        chk("rd_after_wr", 72'(cpu_rdata), 72'hCAFEF00D);
        cpu_addr = 4'd10;
        tick();
        @(negedge clk);
        chk("rd_word5_lo", 72'(cpu_rdata), 72'h33330005);
        chk("proc_pkt_ready", {71'h0, pkt_ready}, 72'h1);

        for (int i = 0; i < 8; i++) begin
            if (i == 5) exp_q.push_back({8'h00, 64'hCAFEF00D_33330005});
            else        exp_q.push_back({ctrl_of(i, 8), 64'h1111_2222_3333_0000 + 64'(i)});
        end
        drain(8, 1'b1);
        chk("after_drain_pkt_ready", {71'h0, pkt_ready}, 72'h0);

        // Oversize packet, then a normal one.
        send_pkt(12, 64'h0D0D_0000_0000_0000, 1'b0);
        chk("ovf_pkt_ready", {71'h0, pkt_ready}, 72'h0);
        chk("ovf_drop_cnt", 72'(drop_cnt), 72'd1);
        chk("ovf_in_rdy", {71'h0, in_rdy}, 72'h1);
        send_pkt(4, 64'hE000_0000_0000_0100, 1'b0);
        chk("post_ovf_pkt_ready", {71'h0, pkt_ready}, 72'h1);
        chk("post_ovf_pkt_len", 72'(pkt_len), 72'd4);
        push_pkt(4, 64'hE000_0000_0000_0100);
        drain(4, 1'b0);

        // Reset while in PROC.
        send_pkt(4, 64'hAAAA_0000_0000_0000, 1'b0);
        chk("pre_rst_pkt_ready", {71'h0, pkt_ready}, 72'h1);
        #1;
        pulse_reset();
        chk("rst_drop_cnt", 72'(drop_cnt), 72'h0);

        // Reset mid-drain, after one word has been presented.
        send_pkt(5, 64'hBBBB_0000_0000_0000, 1'b0);
        chk("pkt5_len", 72'(pkt_len), 72'd5);
        push_pkt(1, 64'hBBBB_0000_0000_0000);
        exp_q[0][71:64] = 8'hFF;
        tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        out_rdy  = 1'b1;
        tick();
        out_rdy  = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_drain_out_wr", {71'h0, out_wr}, 72'h1);
        pulse_reset();
        chk("mid_drain_sb_empty", 72'(exp_q.size()), 72'h0);

        // Fresh packet must land at buffer address 0.
        send_pkt(4, 64'hC0C0_0000_0000_0040, 1'b0);
        chk("fresh_pkt_ready", {71'h0, pkt_ready}, 72'h1);
        chk("fresh_pkt_len", 72'(pkt_len), 72'd4);
        tick();
        cpu_addr = 4'd0;
        tick();
        @(negedge clk);
        chk("fresh_word0_lo", 72'(cpu_rdata), 72'h00000040);
        push_pkt(4, 64'hC0C0_0000_0000_0040);
        drain(4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
